// File: rtl/gw_loader_pkg.sv
// Shared address map, header layout and FSM encoding for the ROM loader and uploader.
package gw_loader_pkg;

    // Region start addresses, in 16-bit word units.
    localparam logic [24:0] IMAGE_START_ADDR = 25'h0000080;
    localparam logic [24:0] MASK_CONFIG_ADDR = 25'h017BB80;
    localparam logic [24:0] ROM_DATA_ADDR    = 25'h0187250;

    localparam logic [7:0] HEADER_VERSION = 8'h01;

    localparam logic [7:0] HDR_MPU           = 8'd1;
    localparam logic [7:0] HDR_SCREEN_CONFIG = 8'd2;
    localparam logic [7:0] HDR_SCREEN_SIZE   = 8'd3;
    localparam logic [7:0] HDR_INPUT_MAP     = 8'd8;
    localparam logic [7:0] HDR_INPUT_B       = 8'd40;
    localparam logic [7:0] HDR_INPUT_BA      = 8'd41;
    localparam logic [7:0] HDR_INPUT_ACL     = 8'd42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD_LO,
        ST_WAIT_LO,
        ST_RD_HI,
        ST_WAIT_HI,
        ST_DONE
    } ld_state_t;

    typedef struct packed {
        logic rom;
        logic mask;
        logic image;
    } region_t;

endpackage

// File: rtl/upload_header_mux.sv
// Rebuilds one byte of the loader header image from the live configuration registers.
module upload_header_mux
    import gw_loader_pkg::*;
(
    input  logic [7:0]   byte_idx_i,
    input  logic [7:0]   mpu_i,
    input  logic [7:0]   screen_config_i,
    input  logic [11:0]  screen_width_i,
    input  logic [11:0]  screen_height_i,
    input  logic [255:0] input_map_i,
    input  logic [7:0]   input_b_i,
    input  logic [7:0]   input_ba_i,
    input  logic [7:0]   input_acl_i,
    output logic [7:0]   byte_o
);

    logic [7:0] map_rel;

    always_comb begin
        map_rel = byte_idx_i - HDR_INPUT_MAP;
        byte_o  = 8'h00;
        // Input map: eight 32-bit words stored little-endian starting at byte 8.
        if (byte_idx_i >= HDR_INPUT_MAP && byte_idx_i < HDR_INPUT_B) begin
            byte_o = input_map_i[{map_rel[4:0], 3'b000} +: 8];
        end else begin
            case (byte_idx_i)
                8'd0:                   byte_o = HEADER_VERSION;
                HDR_MPU:                byte_o = mpu_i;
                HDR_SCREEN_CONFIG:      byte_o = screen_config_i;
                HDR_SCREEN_SIZE:        byte_o = screen_width_i[7:0];
                HDR_SCREEN_SIZE + 8'd1: byte_o = {screen_height_i[3:0], screen_width_i[11:8]};
                HDR_SCREEN_SIZE + 8'd2: byte_o = screen_height_i[11:4];
                HDR_INPUT_B:            byte_o = input_b_i;
                HDR_INPUT_BA:           byte_o = input_ba_i;
                HDR_INPUT_ACL:          byte_o = input_acl_i;
                default:                byte_o = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/rom_uploader.sv
// Answers host ioctl upload word reads: header words from config, other regions via two byte reads.
module rom_uploader
    import gw_loader_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    input  logic [7:0]  mpu,
    input  logic [7:0]  screen_config,
    input  logic [11:0] screen_width,
    input  logic [11:0] screen_height,
    input  logic [31:0] input_s0_config,
    input  logic [31:0] input_s1_config,
    input  logic [31:0] input_s2_config,
    input  logic [31:0] input_s3_config,
    input  logic [31:0] input_s4_config,
    input  logic [31:0] input_s5_config,
    input  logic [31:0] input_s6_config,
    input  logic [31:0] input_s7_config,
    input  logic [7:0]  input_b_config,
    input  logic [7:0]  input_ba_config,
    input  logic [7:0]  input_acl_config,
    output logic        rd_8bit,
    output logic [25:0] addr_8bit,
    input  logic [7:0]  data_8bit,
    output logic        image_upload,
    output logic        mask_config_upload,
    output logic        rom_upload
);

    // Wait-state counts: low byte captured on the last WAIT_LO cycle, high byte in DONE.
    localparam logic [2:0] LO_WAIT = 3'(READ_LATENCY - 1);
    localparam logic [2:0] HI_WAIT = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

    ld_state_t   state_q, state_d;
    logic [15:0] din_q, din_d;
    logic [7:0]  lo_q, lo_d;
    logic [25:0] addr_q, addr_d;
    logic [2:0]  cnt_q, cnt_d;
    region_t     region_q, region_d;

    logic [255:0] input_map;
    logic [7:0]   hdr_byte [2];
    region_t      region_sel;
    logic [24:0]  base;

    assign input_map = {input_s7_config, input_s6_config, input_s5_config, input_s4_config,
                        input_s3_config, input_s2_config, input_s1_config, input_s0_config};

    for (genvar gi = 0; gi < 2; gi++) begin : g_hdr
        upload_header_mux u_mux (
            .byte_idx_i      ({ioctl_addr[6:0], 1'(gi)}),
            .mpu_i           (mpu),
            .screen_config_i (screen_config),
            .screen_width_i  (screen_width),
            .screen_height_i (screen_height),
            .input_map_i     (input_map),
            .input_b_i       (input_b_config),
            .input_ba_i      (input_ba_config),
            .input_acl_i     (input_acl_config),
            .byte_o          (hdr_byte[gi])
        );
    end

    always_comb begin
        region_sel = '0;
        if (ioctl_addr >= ROM_DATA_ADDR) begin
            region_sel.rom = 1'b1;
            base           = ioctl_addr - ROM_DATA_ADDR;
        end else if (ioctl_addr >= MASK_CONFIG_ADDR) begin
            region_sel.mask = 1'b1;
            base            = ioctl_addr - MASK_CONFIG_ADDR;
        end else begin
            region_sel.image = 1'b1;
            base             = ioctl_addr - IMAGE_START_ADDR;
        end
    end

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        lo_d     = lo_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        region_d = region_q;
        if (!ioctl_upload && state_q != ST_IDLE) begin
            // Host abandoned the session: drop any byte in flight, keep the last word.
            state_d  = ST_IDLE;
            region_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ioctl_rd && ioctl_upload) begin
                        if (ioctl_addr < IMAGE_START_ADDR) begin
                            din_d   = {hdr_byte[1], hdr_byte[0]};
                            state_d = ST_HDR;
                        end else begin
                            addr_d   = {base, 1'b0};
                            region_d = region_sel;
                            state_d  = ST_RD_LO;
                        end
                    end
                end
                ST_HDR: state_d = ST_IDLE;
                ST_RD_LO: begin
                    cnt_d   = LO_WAIT;
                    state_d = ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (cnt_q == 3'd0) begin
                        lo_d      = data_8bit;
                        addr_d[0] = 1'b1;
                        state_d   = ST_RD_HI;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_RD_HI: begin
                    if (READ_LATENCY == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = HI_WAIT;
                        state_d = ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (cnt_q == 3'd0) state_d = ST_DONE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                ST_DONE: begin
                    din_d    = {data_8bit, lo_q};
                    region_d = '0;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            din_q    <= 16'h0000;
            lo_q     <= 8'h00;
            addr_q   <= 26'd0;
            cnt_q    <= 3'd0;
            region_q <= '0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            lo_q     <= lo_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            region_q <= region_d;
        end
    end

    assign ioctl_din          = din_q;
    assign addr_8bit          = addr_q;
    assign ioctl_wait         = (state_q != ST_IDLE) && (state_q != ST_HDR);
    assign rd_8bit            = (state_q == ST_RD_LO) || (state_q == ST_RD_HI);
    assign image_upload       = region_q.image;
    assign mask_config_upload = region_q.mask;
    assign rom_upload         = region_q.rom;

endmodule

// File: tb/tb_rom_uploader.sv
// Randomised bench for rom_uploader: timeline model of each word fetch plus directed literal checks.
module tb_rom_uploader;

    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ioctl_upload, ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic [7:0]  mpu, screen_config;
    logic [11:0] screen_width, screen_height;
    logic [31:0] s_cfg [8];
    logic [7:0]  cfg_b, cfg_ba, cfg_acl;
    logic        rd_8bit;
    logic [25:0] addr_8bit;
    logic [7:0]  data_8bit = 8'h00;
    logic        image_upload, mask_config_upload, rom_upload;

    rom_uploader #(.READ_LATENCY(L)) dut (
        .clk                (clk),
        .reset              (reset),
        .ioctl_upload       (ioctl_upload),
        .ioctl_rd           (ioctl_rd),
        .ioctl_addr         (ioctl_addr),
        .ioctl_din          (ioctl_din),
        .ioctl_wait         (ioctl_wait),
        .mpu                (mpu),
        .screen_config      (screen_config),
        .screen_width       (screen_width),
        .screen_height      (screen_height),
        .input_s0_config    (s_cfg[0]),
        .input_s1_config    (s_cfg[1]),
        .input_s2_config    (s_cfg[2]),
        .input_s3_config    (s_cfg[3]),
        .input_s4_config    (s_cfg[4]),
        .input_s5_config    (s_cfg[5]),
        .input_s6_config    (s_cfg[6]),
        .input_s7_config    (s_cfg[7]),
        .input_b_config     (cfg_b),
        .input_ba_config    (cfg_ba),
        .input_acl_config   (cfg_acl),
        .rd_8bit            (rd_8bit),
        .addr_8bit          (addr_8bit),
        .data_8bit          (data_8bit),
        .image_upload       (image_upload),
        .mask_config_upload (mask_config_upload),
        .rom_upload         (rom_upload)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_count = 0;
    logic [7:0] seed8 = 8'h00;
    logic [7:0] mem_ovr [logic [28:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Byte-wide memory contents: a hash of region and byte address, with directed overrides.
    function automatic logic [7:0] mem_byte(input logic [2:0] r, input logic [25:0] a);
        logic [25:0] h;
        if (mem_ovr.exists({r, a})) return mem_ovr[{r, a}];
        h = a * 26'd37;
        return h[10:3] ^ a[7:0] ^ {r, 5'b10101} ^ seed8;
    endfunction

    function automatic logic [7:0] hdr_byte(input int i);
        int v;
        v = 0;
        if (i == 0)                v = 1;
        else if (i == 1)           v = int'(mpu);
        else if (i == 2)           v = int'(screen_config);
        else if (i == 3)           v = int'(screen_width) % 256;
        else if (i == 4)           v = (int'(screen_height) % 16) * 16 + int'(screen_width) / 256;
        else if (i == 5)           v = int'(screen_height) / 16;
        else if (i >= 8 && i < 40) v = int'((s_cfg[(i - 8) / 4] >> (8 * ((i - 8) % 4))) & 32'hFF);
        else if (i == 40)          v = int'(cfg_b);
        else if (i == 41)          v = int'(cfg_ba);
        else if (i == 42)          v = int'(cfg_acl);
        return 8'(v);
    endfunction

    // Memory responder: returns the addressed byte exactly L cycles after each strobe, junk otherwise.
    logic       sch_v [8] = '{default: 1'b0};
    logic [7:0] sch_d [8];
    always @(negedge clk) begin
        int slot;
        if (rd_8bit === 1'b1) begin
            rd_count++;
            slot = (cyc + L) % 8;
            sch_v[slot] = 1'b1;
            sch_d[slot] = mem_byte({rom_upload, mask_config_upload, image_upload}, addr_8bit);
        end
        slot = cyc % 8;
        if (sch_v[slot]) begin
            data_8bit   = sch_d[slot];
            sch_v[slot] = 1'b0;
        end else begin
            data_8bit = 8'($urandom);
        end
    end

    // Reference model: one outstanding transaction described by its start cycle.
    logic        m_valid = 1'b0, m_busy = 1'b0, m_hdr = 1'b0;
    int          m_t0 = 0;
    logic [15:0] m_din = 16'h0, m_word = 16'h0;
    logic [25:0] m_addr = 26'd0;
    logic [24:0] m_base = 25'd0;
    logic [2:0]  m_reg = 3'd0;

    always @(negedge clk) begin
        int k, a;
        logic e_wait, e_rd;
        logic [2:0] e_reg;
        logic [25:0] e_addr;
        k = cyc - m_t0;
        e_wait = 1'b0; e_rd = 1'b0; e_reg = 3'd0; e_addr = m_addr;
        if (m_busy && !m_hdr) begin
            e_wait = 1'b1;
            e_rd   = (k == 1) || (k == 2 + L);
            e_reg  = m_reg;
            e_addr = {m_base, 1'(k >= 2 + L)};
        end
        if (m_valid) begin
            chk("din",   32'(ioctl_din), 32'(m_din));
            chk("wait",  32'(ioctl_wait), 32'(e_wait));
            chk("rd8",   32'(rd_8bit), 32'(e_rd));
            chk("addr8", 32'(addr_8bit), 32'(e_addr));
            chk("flags", 32'({rom_upload, mask_config_upload, image_upload}), 32'(e_reg));
        end
        m_addr = e_addr;
        if (reset === 1'b1) begin
            m_valid = 1'b1; m_busy = 1'b0; m_din = 16'h0; m_addr = 26'd0;
        end else if (m_busy && !ioctl_upload) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_hdr || k == 2 + 2 * L) begin
                m_busy = 1'b0;
                if (!m_hdr) m_din = m_word;
            end
        end else if (ioctl_upload && ioctl_rd) begin
            m_busy = 1'b1;
            m_t0   = cyc;
            a      = int'(ioctl_addr);
            m_hdr  = (a < 'h80);
            if (m_hdr) begin
                m_din = {hdr_byte(2 * a + 1), hdr_byte(2 * a)};
            end else begin
                if (a >= 'h187250)      begin m_reg = 3'b100; m_base = 25'(a - 'h187250); end
                else if (a >= 'h17BB80) begin m_reg = 3'b010; m_base = 25'(a - 'h17BB80); end
                else                    begin m_reg = 3'b001; m_base = 25'(a - 'h80); end
                m_word = {mem_byte(m_reg, {m_base, 1'b1}), mem_byte(m_reg, {m_base, 1'b0})};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hdr_read(input logic [24:0] a, input logic [15:0] exp, input string name);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        #2;
        chk(name, 32'(ioctl_din), 32'(exp));
        chk({name, "_wait"}, 32'(ioctl_wait), 32'd0);
        tick();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_din"},   32'(ioctl_din), 32'd0);
        chk({name, "_wait"},  32'(ioctl_wait), 32'd0);
        chk({name, "_rd"},    32'(rd_8bit), 32'd0);
        chk({name, "_addr"},  32'(addr_8bit), 32'd0);
        chk({name, "_flags"}, 32'({rom_upload, mask_config_upload, image_upload}), 32'd0);
    endtask

    function automatic logic [24:0] pick_addr();
        int bnd [9] = '{0, 'h7F, 'h80, 'h81, 'h17BB7F, 'h17BB80, 'h18724F, 'h187250, 'h1FFFFFF};
        case ($urandom_range(0, 5))
            0:       return 25'($urandom_range(0, 127));
            1:       return 25'(bnd[$urandom_range(0, 8)]);
            2:       return 25'($urandom_range('h80, 'h17BB7F));
            3:       return 25'($urandom_range('h17BB80, 'h18724F));
            4:       return 25'($urandom_range('h187250, 'h1FFFFFF));
            default: return 25'($urandom);
        endcase
    endfunction

    task automatic randomize_cfg();
        mpu = 8'($urandom); screen_config = 8'($urandom);
        screen_width = 12'($urandom); screen_height = 12'($urandom);
        for (int i = 0; i < 8; i++) s_cfg[i] = $urandom;
        cfg_b = 8'($urandom); cfg_ba = 8'($urandom); cfg_acl = 8'($urandom);
    endtask

    initial begin
        int rc0;
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = 25'd0;
        seed8 = 8'($urandom);
        randomize_cfg();
        repeat (3) tick();
        #2;
        chk_zero("reset");
        tick();
        reset = 1'b0; ioctl_upload = 1'b1;
        mpu = 8'h05; screen_config = 8'h03;
        screen_width = 12'h2D0; screen_height = 12'h1E0;
        s_cfg[1] = 32'hAABBCCDD;
        cfg_b = 8'h11; cfg_ba = 8'h22; cfg_acl = 8'h33;
        tick();

        hdr_read(25'd0,   16'h0501, "hdr_w0");
        hdr_read(25'd1,   16'hD003, "hdr_w1");
        hdr_read(25'd2,   16'h1E02, "hdr_w2");
        hdr_read(25'd3,   16'h0000, "hdr_w3");
        hdr_read(25'd6,   16'hCCDD, "hdr_w6");
        hdr_read(25'd7,   16'hAABB, "hdr_w7");
        hdr_read(25'd20,  16'h2211, "hdr_w20");
        hdr_read(25'd21,  16'h0033, "hdr_w21");
        hdr_read(25'h7F,  16'h0000, "hdr_w7f");

        // Image word 0x80: two byte reads, word valid at cycle 3+2L.
        mem_ovr[{3'b001, 26'd0}] = 8'h34;
        mem_ovr[{3'b001, 26'd1}] = 8'h12;
        ioctl_addr = 25'h80; ioctl_rd = 1'b1;
        tick(); ioctl_rd = 1'b0; #2;
        chk("img_c1_addr", 32'(addr_8bit), 32'd0);
        chk("img_c1_flag", 32'({rom_upload, mask_config_upload, image_upload}), 32'b001);
        chk("img_c1_wait", 32'(ioctl_wait), 32'd1);
        chk("img_c1_rd",   32'(rd_8bit), 32'd1);
        repeat (3) tick(); #2;
        chk("img_c4_addr", 32'(addr_8bit), 32'd1);
        chk("img_c4_rd",   32'(rd_8bit), 32'd1);
        repeat (2) tick(); #2;
        chk("img_c6_wait", 32'(ioctl_wait), 32'd1);
        tick(); #2;
        chk("img_c7_din",  32'(ioctl_din), 32'h1234);
        chk("img_c7_wait", 32'(ioctl_wait), 32'd0);
        tick();

        // ROM word with a read request arriving mid-fetch that must be ignored.
        mem_ovr[{3'b100, 26'd2}] = 8'hBE;
        mem_ovr[{3'b100, 26'd3}] = 8'hEF;
        rc0 = rd_count;
        ioctl_addr = 25'h187251; ioctl_rd = 1'b1;
        tick(); ioctl_rd = 1'b0; #2;
        chk("rom_c1_addr", 32'(addr_8bit), 32'd2);
        chk("rom_c1_flag", 32'({rom_upload, mask_config_upload, image_upload}), 32'b100);
        tick(); ioctl_addr = 25'd0; ioctl_rd = 1'b1;
        tick(); ioctl_rd = 1'b0;
        tick(); #2;
        chk("rom_c4_addr", 32'(addr_8bit), 32'd3);
        repeat (3) tick(); #2;
        chk("rom_c7_din",  32'(ioctl_din), 32'hEFBE);
        chk("rom_rd_count", 32'(rd_count - rc0), 32'd2);
        tick();

        // Upload drops at cycle 3: idle at cycle 4 with the previous word kept.
        ioctl_addr = 25'h85; ioctl_rd = 1'b1;
        tick(); ioctl_rd = 1'b0;
        repeat (2) tick(); ioctl_upload = 1'b0;
        tick(); #2;
        chk("abort_wait",  32'(ioctl_wait), 32'd0);
        chk("abort_flags", 32'({rom_upload, mask_config_upload, image_upload}), 32'd0);
        chk("abort_din",   32'(ioctl_din), 32'hEFBE);
        ioctl_upload = 1'b1;
        tick();

        // Reset in the middle of a fetch, then a header read must still work.
        ioctl_addr = 25'h17BB80; ioctl_rd = 1'b1;
        tick(); ioctl_rd = 1'b0;
        repeat (2) tick(); reset = 1'b1;
        tick(); reset = 1'b0; #2;
        chk_zero("midrst");
        tick();
        hdr_read(25'd0, 16'h0501, "post_rst_w0");

        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 999) == 0);
            ioctl_upload = ($urandom_range(0, 99) >= 2);
            ioctl_rd     = ($urandom_range(0, 2) == 0);
            ioctl_addr   = pick_addr();
            if ($urandom_range(0, 49) == 0) randomize_cfg();
            tick();
        end
        reset = 1'b0; ioctl_upload = 1'b1; ioctl_rd = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
